ones_frame_accumulator: RTL
===========================

Name: ones_frame_accumulator

Overview:
- Downstream stage of the 4-bit ones-counter. It consumes that counter's 3-bit per-nibble results, one beat per nibble, and accumulates the total number of ones over a frame of nibbles.
- The frame result is presented on a valid/ready output with status flags.
- Frames are delimited by in_last or by a maximum nibble count.

Parameters:
- MAX_NIBBLES, 16, maximum beats per frame; the frame is force-closed on reaching it; legal range 1..255.
- SUM_W, 7, width of out_sum; default holds 16*4=64 without saturation.
- CNT_W, 8, width of out_nibbles; must hold MAX_NIBBLES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- In  input  3  per-nibble ones count, legal values 0..4
- in_valid  input  1  In and in_last are valid
- in_last  input  1  current beat is the final nibble of the frame
- in_ready  output  1  block accepts a beat this cycle
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes the result
- out_sum  output  SUM_W  total ones in the frame (saturating)
- out_nibbles  output  CNT_W  number of beats accepted in the frame
- out_ovf  output  1  out_sum saturated during the frame
- out_trunc  output  1  frame closed by MAX_NIBBLES, not by in_last
- out_err  output  1  at least one illegal In value (5..7) seen in the frame

Behaviour:
- Decided: one clock; reset is synchronous and active-high (clk, rst). All state is updated on the rising edge of clk only.
- Reset (rst=1 at a clock edge):
  - state goes to IDLE;
  - out_sum, out_nibbles, out_ovf, out_trunc, out_err and out_valid are all 0;
  - in_ready goes to 1 in the first cycle after reset.
  - Reset mid-frame or in HOLD discards all partial or unread results with no output.
- Accept: a beat is accepted when in_valid & in_ready at a clock edge.
- Beat value: the value added is In when In<=4. When In is 5..7 the value added is 0, out_err is set sticky for the frame, and the beat is still counted in out_nibbles.
- States:
  - IDLE: in_ready=1, out_valid=0. On an accepted beat:
    - load out_sum=value, out_nibbles=1;
    - clear ovf/trunc/err, then apply this beat's err;
    - go to HOLD if in_last=1 or MAX_NIBBLES=1 (trunc=1 only when in_last=0); otherwise go to ACC.
  - ACC: in_ready=1, out_valid=0. On an accepted beat:
    - out_sum += value, with saturation: if the true sum exceeds 2^SUM_W-1, out_sum=2^SUM_W-1 and out_ovf=1 sticky;
    - out_nibbles += 1;
    - if in_last=1, go to HOLD;
    - else if the new out_nibbles == MAX_NIBBLES, go to HOLD with out_trunc=1;
    - in_last coincident with reaching MAX_NIBBLES gives HOLD with out_trunc=0.
    - Idle cycles (in_valid=0) hold all state.
  - HOLD: in_ready=0, out_valid=1.
    - All out_* are stable while out_valid=1 and out_ready=0.
    - On out_ready=1, go to IDLE. out_valid deasserts the next cycle; in_ready rises that same cycle.
    - No beat is accepted in the HOLD-exit cycle.
- Latency: out_valid asserts the cycle after the edge that accepts the closing beat. Minimum frame period is (beats + 1) cycles with out_ready tied high.
- Out-of-frame outputs: out_sum/out_nibbles/flags keep their last frame values in IDLE/ACC until the next frame's first accepted beat overwrites them. They are meaningful only while out_valid=1.
- in_valid while in_ready=0: ignored; the upstream must hold the beat.
- Implementation: no combinational path from out_ready to out_* data. in_ready is a function of state only.

Test Plan:
1. rst then beats In=4,2,1 with in_last on the 3rd, out_ready=1 -> out_valid=1 one cycle after the 3rd accept; out_sum=7, out_nibbles=3, ovf/trunc/err=0; IDLE next cycle.
2. Frame In=3 (last) with out_ready=0 for 5 cycles and in_valid held high with In=2 -> in_ready=0 and out_sum=3 stable for 5 cycles. On out_ready=1 the block returns to IDLE, then accepts In=2.
3. 16 beats In=4, in_last=0 (defaults) -> HOLD after the 16th beat; out_sum=64, out_nibbles=16, out_trunc=1. A 17th beat is not accepted until the result is taken.
4. Beats In=6, In=2 (last) -> out_sum=2, out_nibbles=2, out_err=1. The next frame with In=1 (last) gives out_err=0.
5. SUM_W=5: 10 beats In=4, last on the 10th -> out_sum=31, out_ovf=1, out_nibbles=10, out_trunc=0.
6. rst asserted after 2 beats of In=4 mid-frame, then In=2 (last) -> all outputs 0 during reset, no out_valid for the aborted frame; new result out_sum=2, out_nibbles=1.

Source files
------------

// File: rtl/ones_frame_accumulator_if.sv
// Beat input stream and frame-result output stream of the ones frame accumulator.
// slave is the accumulator side; master is the producer/consumer side.
interface ones_frame_accumulator_if #(
  parameter int unsigned SUM_W = 7,
  parameter int unsigned CNT_W = 8
);
  logic [2:0]       In;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_nibbles;
  logic             out_ovf;
  logic             out_trunc;
  logic             out_err;

  modport slave (
    input  In, in_valid, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_nibbles, out_ovf, out_trunc, out_err
  );

  modport master (
    output In, in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_nibbles, out_ovf, out_trunc, out_err
  );
endinterface

// File: rtl/ones_frame_accumulator.sv
// Accumulates per-nibble ones counts (0..4) over a frame closed by in_last or
// MAX_NIBBLES; holds the saturated total plus status flags until taken.
module ones_frame_accumulator #(
  parameter int unsigned MAX_NIBBLES = 16,
  parameter int unsigned SUM_W       = 7,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ones_frame_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  localparam logic [SUM_W:0]   SUM_MAX = {1'b0, {SUM_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NIBBLES);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] nib_q, nib_d;
  logic             ovf_q, ovf_d;
  logic             trunc_q, trunc_d;
  logic             err_q, err_d;

  logic             first;
  logic             beat_err;
  logic [2:0]       beat_val;
  logic [SUM_W:0]   sum_base;
  logic [SUM_W:0]   sum_true;
  logic             sum_over;
  logic [CNT_W-1:0] nib_next;
  logic             at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      nib_q   <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      nib_q   <= nib_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
      err_q   <= err_d;
    end
  end

  // IDLE and ACC share one datapath: IDLE simply starts from a zero base.
  always_comb begin
    first    = (state_q == IDLE);
    beat_err = (bus.In > 3'd4);
    beat_val = beat_err ? 3'd0 : bus.In;
    sum_base = first ? '0 : {1'b0, sum_q};
    sum_true = sum_base + (SUM_W + 1)'(beat_val);
    sum_over = (sum_true > SUM_MAX);
    nib_next = first ? CNT_W'(1) : nib_q + CNT_W'(1);
    at_max   = (nib_next == CNT_MAX);
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    nib_d   = nib_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, ACC: begin
        if (bus.in_valid) begin
          sum_d   = sum_over ? SUM_MAX[SUM_W-1:0] : sum_true[SUM_W-1:0];
          nib_d   = nib_next;
          ovf_d   = (first ? 1'b0 : ovf_q) | sum_over;
          err_d   = (first ? 1'b0 : err_q) | beat_err;
          trunc_d = !bus.in_last && at_max;
          state_d = (bus.in_last || at_max) ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q != HOLD);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_sum     = sum_q;
  assign bus.out_nibbles = nib_q;
  assign bus.out_ovf     = ovf_q;
  assign bus.out_trunc   = trunc_q;
  assign bus.out_err     = err_q;

endmodule
